affine_seq: RTL and testbench

//  Sequencer that drives the shared picoMIPS ALU (ADD / Q1.7 MUL) to compute a 2-D affine map:
//  x_out = A11*x + A12*y + B1 ; y_out = A21*x + A22*y + B2.

---
 rtl/affine_pkg.sv | 16 +
 rtl/alu_pkg.sv | 7 +
 rtl/alu.sv | 22 ++
 rtl/affine_seq.sv | 131 +++++++++++++
 tb/tb_affine_seq.sv | 127 ++++++++++++
 5 files changed

// File: rtl/affine_pkg.sv
// rtl/affine_pkg.sv - sequencer state encoding and default affine coefficients
package affine_pkg;

  typedef enum logic [3:0] {
    IDLE, M1, M2, A1, A2, M3, M4, A3, A4, DONE
  } state_e;

  localparam int DEF_N   = 8;
  localparam int DEF_A11 = 96;
  localparam int DEF_A12 = 64;
  localparam int DEF_A21 = -64;
  localparam int DEF_A22 = 96;
  localparam int DEF_B1  = 20;
  localparam int DEF_B2  = -20;

endpackage

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared picoMIPS ALU function codes
package alu_pkg;

  localparam logic RADD = 1'b0;
  localparam logic RMUL = 1'b1;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - shared picoMIPS ALU: wrapping add and Q1.7 fractional multiply
module alu
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         func,
  output logic [N-1:0] result
);

  logic signed [2*N-1:0] prod;

  always_comb begin
    prod   = $signed(a) * $signed(b);
    result = a + b;
    // Fractional multiply keeps bits [2N-2:N-1], i.e. floor(product / 2^(N-1)).
    if (func == RMUL) result = prod[2*N-2:N-1];
  end

endmodule

// File: rtl/affine_seq.sv
// rtl/affine_seq.sv - drives the shared ALU one op per cycle to compute a 2-D affine map
module affine_seq
  import affine_pkg::*;
  import alu_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int A11 = DEF_A11,
  parameter int A12 = DEF_A12,
  parameter int A21 = DEF_A21,
  parameter int A22 = DEF_A22,
  parameter int B1  = DEF_B1,
  parameter int B2  = DEF_B2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] x_in,
  input  logic [N-1:0] y_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] x_out,
  output logic [N-1:0] y_out,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         alu_func,
  input  logic [N-1:0] alu_result
);

  localparam logic [N-1:0] A11_V = N'(A11);
  localparam logic [N-1:0] A12_V = N'(A12);
  localparam logic [N-1:0] A21_V = N'(A21);
  localparam logic [N-1:0] A22_V = N'(A22);
  localparam logic [N-1:0] B1_V  = N'(B1);
  localparam logic [N-1:0] B2_V  = N'(B2);

  state_e       state_q, state_d;
  logic [N-1:0] x_q, x_d, y_q, y_d;
  logic [N-1:0] t0_q, t0_d, t1_q, t1_d;
  logic [N-1:0] x_out_q, x_out_d, y_out_q, y_out_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
    end
  end

  // Each state issues one ALU op; its result is captured on the edge leaving the state.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    t0_d     = t0_q;
    t1_d     = t1_q;
    x_out_d  = x_out_q;
    y_out_d  = y_out_q;
    alu_a    = '0;
    alu_b    = '0;
    alu_func = RADD;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = M1;
          x_d     = x_in;
          y_d     = y_in;
        end
      end
      M1: begin
        alu_func = RMUL; alu_a = A11_V; alu_b = x_q;
        t0_d = alu_result; state_d = M2;
      end
      M2: begin
        alu_func = RMUL; alu_a = A12_V; alu_b = y_q;
        t1_d = alu_result; state_d = A1;
      end
      A1: begin
        alu_a = t0_q; alu_b = t1_q;
        t0_d = alu_result; state_d = A2;
      end
      A2: begin
        alu_a = t0_q; alu_b = B1_V;
        x_out_d = alu_result; state_d = M3;
      end
      M3: begin
        alu_func = RMUL; alu_a = A21_V; alu_b = x_q;
        t0_d = alu_result; state_d = M4;
      end
      M4: begin
        alu_func = RMUL; alu_a = A22_V; alu_b = y_q;
        t1_d = alu_result; state_d = A3;
      end
      A3: begin
        alu_a = t0_q; alu_b = t1_q;
        t0_d = alu_result; state_d = A4;
      end
      A4: begin
        alu_a = t0_q; alu_b = B2_V;
        y_out_d = alu_result; state_d = DONE;
      end
      DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign x_out = x_out_q;
  assign y_out = y_out_q;

endmodule

// File: tb/tb_affine_seq.sv
// tb/tb_affine_seq.sv - scoreboard bench for affine_seq wired to the shared ALU
module tb_affine_seq;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] x_in = '0, y_in = '0;
  logic       busy, done, alu_func;
  logic [7:0] x_out, y_out, alu_a, alu_b, alu_result;

  int checks = 0;
  int errors = 0;

  typedef struct { int x; int y; } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  affine_seq dut (
    .clk(clk), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
    .busy(busy), .done(done), .x_out(x_out), .y_out(y_out),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_result(alu_result)
  );

  alu #(.N(8)) u_alu (.a(alu_a), .b(alu_b), .func(alu_func), .result(alu_result));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding job.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("x_out", int'($signed(x_out)), e.x);
        check("y_out", int'($signed(y_out)), e.y);
      end
    end
  end

  task automatic run_job(input int x, input int y, input int ex, input int ey, input bit pulse);
    logic exp_func [0:7];
    exp_func = '{RMUL, RMUL, RADD, RADD, RMUL, RMUL, RADD, RADD};
    @(negedge clk);
    x_in  = 8'(x);
    y_in  = 8'(y);
    start = 1'b1;
    exp_q.push_back('{x: ex, y: ey});
    @(posedge clk);
    #1 start = 1'b0;
    if (pulse) begin
      x_in = 8'd99;
      y_in = 8'd77;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("alu_func_%0d", k), int'(alu_func), int'(exp_func[k]));
      check($sformatf("busy_%0d", k), int'(busy), 1);
      check($sformatf("no_early_done_%0d", k), int'(done), 0);
      if (pulse && k == 2) start = 1'b1;
      if (pulse && k == 3) start = 1'b0;
    end
    @(negedge clk);
    check("done_latency", int'(done), 1);
    check("busy_in_done", int'(busy), 0);
    if (pulse) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("idle_after_done", int'(busy), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_x_out", int'(x_out), 0);
    check("rst_y_out", int'(y_out), 0);
    check("rst_alu_func", int'(alu_func), int'(RADD));
    check("rst_alu_a", int'(alu_a), 0);
    check("rst_alu_b", int'(alu_b), 0);

    run_job(40, 20, 60, -25, 1'b0);
    run_job(127, 127, -78, 11, 1'b0);
    run_job(-1, 0, 19, -20, 1'b0);
    run_job(-128, -128, 116, -52, 1'b0);
    run_job(40, 20, 60, -25, 1'b1);

    // Abort a job in A3 with reset; the monitor flags any done from it.
    @(negedge clk);
    x_in  = 8'd40;
    y_in  = 8'd20;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(negedge clk);
    check("abort_busy_before", int'(busy), 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_x_out", int'(x_out), 0);
    check("abort_y_out", int'(y_out), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    run_job(40, 20, 60, -25, 1'b0);

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
